// File: rtl/mc_buffered_caster.sv
// -----------------------------------------------------------------------------
// mc_buffered_caster
//
// Column caster for a shared broadcast bus. Each caster watches every beat on
// the bus and keeps only those addressed to its column (tag match) or marked
// as broadcast. Kept beats are queued in a small first-word-fall-through FIFO
// that feeds the local PE. Beats for other columns are consumed immediately,
// so an unaddressed caster never back-pressures the shared bus.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   cfg_id       this caster's column ID (static during operation)
//   caster_en    accept enable; stored entries still drain when low
//   flush        synchronous clear of FIFO contents and hit counter
//   in_valid     bus beat valid
//   in_ready     ready toward the bus (combinational)
//   in_tag       destination column tag of the beat
//   in_bcast     broadcast beat; tag ignored
//   in_data      bus payload
//   pe_valid     head entry valid toward the PE
//   pe_ready     PE ready
//   pe_data      head entry payload (zero when nothing is stored)
//   occupancy    number of stored entries
//   hit_cnt      saturating count of accepted beats
// -----------------------------------------------------------------------------
module mc_buffered_caster #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned ID_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_W-1:0]       cfg_id,
    input  logic                  caster_en,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_W-1:0]       in_tag,
    input  logic                  in_bcast,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  pe_valid,
    input  logic                  pe_ready,
    output logic [DATA_WIDTH-1:0] pe_data,
    output logic [OCC_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      hit_cnt
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    // Storage and pointers. Pointers carry one extra wrap bit so that full and
    // empty can be told apart without a separate count register.
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;

    logic             match;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] occ_diff;

    assign match = caster_en & (in_bcast | (in_tag == cfg_id));

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Misses are always accepted (and dropped); hits wait for space. Full is
    // judged on the current state only, so a same-cycle pop never frees room.
    always_comb begin
        if (flush) begin
            in_ready = 1'b0;
        end else if (!match) begin
            in_ready = 1'b1;
        end else begin
            in_ready = !full;
        end
    end

    assign push = in_valid & in_ready & match;
    assign pop  = pe_valid & pe_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hit_cnt_d = hit_cnt_q;
        if (flush) begin
            // Any pop this cycle is discarded along with the contents.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            hit_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (hit_cnt_q != {CNT_W{1'b1}}) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hit_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Payload RAM needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // Modulo-2*DEPTH difference is the exact entry count.
    assign occ_diff  = wr_ptr_q - rd_ptr_q;
    assign occupancy = OCC_W'(occ_diff);
    assign pe_valid  = !empty;
    // Gate the head so pe_data reads zero whenever nothing is stored,
    // including throughout reset.
    assign pe_data   = pe_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_mc_buffered_caster.sv
// -----------------------------------------------------------------------------
// tb_mc_buffered_caster
//
// Directed bench for mc_buffered_caster with a queue-based reference model.
// The model is updated on every rising edge (and cleared on reset); a single
// negedge process compares every DUT output against it each cycle. Directed
// sections additionally check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_mc_buffered_caster;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int FD = 4;
    localparam int CW = 16;
    localparam int IW = 2;
    localparam int OW = 3;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] cfg_id;
    logic          caster_en;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_tag;
    logic          in_bcast;
    logic [DW-1:0] in_data;
    logic          pe_valid;
    logic          pe_ready;
    logic [DW-1:0] pe_data;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] hit_cnt;

    mc_buffered_caster #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC),
        .FIFO_DEPTH (FD),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_id    (cfg_id),
        .caster_en (caster_en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tag    (in_tag),
        .in_bcast  (in_bcast),
        .in_data   (in_data),
        .pe_valid  (pe_valid),
        .pe_ready  (pe_ready),
        .pe_data   (pe_data),
        .occupancy (occupancy),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];
    int            m_hits;
    logic [DW-1:0] dut_out[$];

    function automatic bit m_match();
        return caster_en && (in_bcast || (in_tag == cfg_id));
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (!m_match()) return 1'b1;
        return mq.size() < FD;
    endfunction

    task automatic model_step();
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            mq.delete();
            m_hits = 0;
        end else begin
            do_push = in_valid && m_ready() && m_match();
            do_pop  = (mq.size() != 0) && pe_ready;
            if (flush) begin
                mq.delete();
                m_hits = 0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back(in_data);
                    if (m_hits < (1 << CW) - 1) m_hits++;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc in_ready", in_ready, m_ready());
        check("cyc pe_valid", pe_valid, mq.size() != 0);
        check("cyc occupancy", occupancy, mq.size());
        check("cyc hit_cnt", hit_cnt, m_hits);
        if (mq.size() != 0) check("cyc pe_data", pe_data, mq[0]);
        if (pe_valid && pe_ready && rst_n && !flush) dut_out.push_back(pe_data);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IW-1:0] tag, input logic bc, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_tag   = tag;
        in_bcast = bc;
        in_data  = d;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_bcast = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  i;
        int  guard;
        bit  pr;
        bit  acc;

        rst_n = 1'b1; cfg_id = 2'd2; caster_en = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_tag = '0; in_bcast = 1'b0; in_data = '0; pe_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst pe_valid", pe_valid, 0);
        check("rst occupancy", occupancy, 0);
        check("rst pe_data", pe_data, 0);
        check("rst hit_cnt", hit_cnt, 0);
        check("rst in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Tag match, first push right after reset release.
        caster_en = 1'b1;
        beat(2'd2, 1'b0, 16'h1234);
        tick();
        idle();
        check("match pe_valid", pe_valid, 1);
        check("match pe_data", pe_data, 16'h1234);
        check("match hit_cnt", hit_cnt, 1);
        pe_ready = 1'b1;
        tick();
        pe_ready = 1'b0;
        check("match drained", occupancy, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush hit_cnt", hit_cnt, 0);

        // Tag miss: consumed, never stored.
        for (int k = 0; k < 3; k++) begin
            beat(2'd1, 1'b0, 16'(16'h0100 + k));
            #1 check("miss in_ready", in_ready, 1);
            tick();
        end
        idle();
        check("miss occupancy", occupancy, 0);
        check("miss hit_cnt", hit_cnt, 0);

        // Broadcast fill to full, then drain in order.
        dut_out.delete();
        for (int k = 0; k < 5; k++) begin
            beat(2'd0, 1'b1, 16'(16'h00A0 + k));
            #1;
            if (k == 4) check("full in_ready", in_ready, 0);
            tick();
        end
        idle();
        check("full occupancy", occupancy, 4);
        check("full hit_cnt", hit_cnt, 4);
        pe_ready = 1'b1;
        repeat (4) tick();
        pe_ready = 1'b0;
        check("full drain count", dut_out.size(), 4);
        for (int k = 0; k < dut_out.size() && k < 4; k++)
            check("full order", dut_out[k], 16'(16'h00A0 + k));

        // Wrap-around stream with toggling pe_ready.
        dut_out.delete();
        i = 0; guard = 0; pr = 1'b0;
        while (i < 10 && guard < 100) begin
            beat(2'd2, 1'b0, 16'(i));
            pe_ready = pr;
            #1 acc = in_ready;
            tick();
            pr = !pr;
            if (acc) i++;
            guard++;
        end
        idle();
        while (occupancy != 0 && guard < 100) begin
            pe_ready = pr;
            tick();
            pr = !pr;
            guard++;
        end
        pe_ready = 1'b0;
        check("wrap timeout", guard < 100, 1);
        check("wrap count", dut_out.size(), 10);
        for (int k = 0; k < dut_out.size() && k < 10; k++)
            check("wrap order", dut_out[k], 16'(k));

        // Disabled caster drains but accepts nothing new.
        beat(2'd2, 1'b0, 16'h0077);
        tick();
        caster_en = 1'b0;
        beat(2'd2, 1'b0, 16'h0088);
        #1 check("dis in_ready", in_ready, 1);
        tick();
        idle();
        check("dis occupancy", occupancy, 1);
        check("dis hit_cnt", hit_cnt, 15);
        check("dis head", pe_data, 16'h0077);
        pe_ready = 1'b1;
        tick();
        pe_ready = 1'b0;
        check("dis drained", occupancy, 0);
        caster_en = 1'b1;

        // Flush with a simultaneous matching beat.
        for (int k = 0; k < 3; k++) begin
            beat(2'd2, 1'b0, 16'(16'h0300 + k));
            tick();
        end
        idle();
        check("fl occupancy pre", occupancy, 3);
        flush = 1'b1;
        beat(2'd2, 1'b0, 16'hDEAD);
        #1 check("fl in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        check("fl occupancy", occupancy, 0);
        check("fl hit_cnt", hit_cnt, 0);
        check("fl pe_valid", pe_valid, 0);
        tick();
        check("fl not stored", occupancy, 0);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 2; k++) begin
            beat(2'd2, 1'b0, 16'(16'h0400 + k));
            tick();
        end
        idle();
        check("ar occupancy pre", occupancy, 2);
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("ar pe_valid", pe_valid, 0);
        check("ar occupancy", occupancy, 0);
        check("ar pe_data", pe_data, 0);
        check("ar hit_cnt", hit_cnt, 0);
        tick();
        rst_n = 1'b1;
        beat(2'd2, 1'b0, 16'h5A5A);
        tick();
        idle();
        check("ar new pe_valid", pe_valid, 1);
        check("ar new pe_data", pe_data, 16'h5A5A);
        check("ar new hit_cnt", hit_cnt, 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
